uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

Parametrised UART transmitter: successor to the fixed 8-bit, always-parity transmitter. Accepts one data word per valid/ready handshake and serialises it LSB first as start, DATA_SIZE data bits, optional parity (even/odd) and one or two stop bits. Bit timing is derived from an external oversampling baud tick. Sits between the TX FIFO read side and the pad.

## Interface
- DATA_SIZE, 8: data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: baud_tick pulses per bit time; legal range 4..32.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- baud_tick  input  1  single-cycle strobe at OVERSAMPLE × baud rate.
- tx_valid  input  1  data_in holds a word to send.
- tx_ready  output  1  block accepts a word this cycle. Reset value 0, goes to 1 on the first clock after reset release.
- data_in  input  DATA_SIZE  word to transmit; sampled on accept.
- cfg_parity_en  input  1  append a parity bit; sampled on accept.
- cfg_parity_odd  input  1  1 = odd parity, 0 = even parity; sampled on accept.
- cfg_two_stop  input  1  send two stop bits; sampled on accept.
- send_break  input  1  request a break condition. Used only with UART_TX_BREAK_EN.
- serial_data_out  output  1  TX line, idle high. Reset value 1.
- tx_busy  output  1  a frame or break is in progress. Reset value 0.
- tx_done  output  1  one-cycle pulse after the final stop bit. Reset value 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK. BREAK exists only with the macro.
- IDLE:
  - tx_ready = 1 and the line is high.
  - Accept occurs when tx_valid & tx_ready. On accept, latch data_in and the cfg_* inputs into a shift register and config flops, clear the tick and bit counters, and go to START.
  - The cfg_* inputs are don't-care outside the accept cycle.
- Per-bit timing: the tick counter ($clog2(OVERSAMPLE) bits) increments on each baud_tick. A bit ends on the baud_tick that finds the counter at OVERSAMPLE-1; the counter then wraps to 0.
- START: line 0 for one bit time, then go to DATA.
- DATA:
  - line = shift_reg[0]; shift right at the end of each bit.
  - The bit counter ($clog2(DATA_SIZE) bits) counts 0..DATA_SIZE-1.
  - After the last data bit, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: line = ^data XOR cfg_parity_odd, using the latched data. One bit time, then go to STOP.
- STOP:
  - line 1 for one bit time, or two if cfg_two_stop was latched.
  - At the end of the last stop bit, go to IDLE and register tx_done = 1 for exactly one cycle.
- tx_busy = (state != IDLE).
- baud_tick asserted in the accept cycle is ignored; counting starts on the next cycle.
- tx_valid deasserting mid-frame has no effect. The frame always completes.
- Reset mid-frame:
  - Line forced to 1 immediately (asynchronous) and state goes to IDLE.
  - tx_done is not pulsed and the partial frame is discarded.

## Timing
- The start bit appears on serial_data_out on the cycle after the accept edge.
- Frame length is (1 + DATA_SIZE + P + S) × OVERSAMPLE baud_ticks, where P is 0 or 1 and S is 1 or 2.
- tx_done is high in the first IDLE cycle. tx_ready is also high in that cycle, so back-to-back frames are allowed: an accept there starts the next start bit one cycle later, with no extra idle bit.
- Outputs are registered except tx_ready and tx_busy, which are decoded from registered state.
- With baud_tick tied high, OVERSAMPLE=16 and an 8N1 frame, tx_done rises exactly 160 cycles after the accept edge.

## Configuration
- Macro: UART_TX_BREAK_EN.
- With the macro:
  - send_break sampled high in IDLE (no accept that cycle; break has priority over tx_valid) causes a transition to BREAK.
  - In BREAK: line 0, tx_ready 0, tx_busy 1, for as long as send_break is high, with a minimum of one full frame time ((2 + DATA_SIZE) × OVERSAMPLE ticks).
  - After release, the line is held at 1 for one bit time, then the block returns to IDLE.
  - tx_done is not pulsed for a break.
- Without the macro: send_break is ignored, BREAK is not compiled, and the block behaves as if send_break were tied to 0.

## Structure
- uart_pkg holds:
  - the tx_state_t enum (one-hot, 6 bits);
  - the parity constants PAR_EVEN and PAR_ODD;
  - the default values DATA_SIZE_DEF = 8 and OVERSAMPLE_DEF = 16.
- One sub-module, uart_bit_timer:
  - Contains the tick counter.
  - Inputs: clk, reset, clear, baud_tick.
  - Output: bit_end, a one-cycle pulse at the end of each bit.
  - Reusable by the receiver.
- Top level contains the FSM, the bit counter, the shift register and the parity logic.

## Test plan
- 8N1 frame, data 0xA5, baud_tick tied high, OVERSAMPLE=16 -> line shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles wide. tx_done pulses once, 160 cycles after accept.
- 0xA5 with even parity, then 0xA5 with odd parity -> parity bit is 0, then 1. Frame length is 176 cycles.
- cfg_two_stop=1, data 0x00, no parity -> two stop bits of 16 cycles each. tx_done follows 176 cycles after accept. Changing cfg_* inputs mid-frame does not alter the frame.
- tx_valid held high with three words 0x01, 0x02, 0x03 -> frames are contiguous with no idle gap. tx_ready is high only in IDLE cycles; there are exactly 3 tx_done pulses.
- reset asserted during DATA bit 3 -> serial_data_out = 1 and tx_busy = 0 asynchronously. No tx_done pulse. The next accept sends a clean frame.
- With UART_TX_BREAK_EN: send_break pulsed for 10 cycles, DATA_SIZE=8 -> line low for 160 cycles, then high for 16 cycles, then tx_ready = 1. No tx_done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmitter FSM encoding, parity selectors and the
// default frame/oversampling parameters.
package uart_pkg;

    localparam int unsigned DATA_SIZE_DEF  = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [5:0] {
        StIdle   = 6'b000001,
        StStart  = 6'b000010,
        StData   = 6'b000100,
        StParity = 6'b001000,
        StStop   = 6'b010000,
        StBreak  = 6'b100000
    } tx_state_t;

    // Words narrower than 9 bits are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ (odd == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling bit timer: counts baud ticks and flags the tick that closes each bit period.
// Shared between the UART transmitter and receiver.
module uart_bit_timer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_end
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntMax = CntW'(OVERSAMPLE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // bit_end ignores clear so callers may use it to decide when to clear.
    always_comb begin
        bit_end = baud_tick && (cnt_q == CntMax);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (baud_tick) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Parametrised UART transmitter: start, DATA_SIZE data bits LSB first, optional parity, 1-2 stops.
// Define UART_TX_BREAK_EN to build in the send_break line-break generator.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = DATA_SIZE_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_two_stop,
    input  logic                 send_break,
    output logic                 serial_data_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BitW = $clog2(DATA_SIZE);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_SIZE - 1);

    tx_state_t state_q, state_d;

    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 line_q, line_d;
    logic                 done_q, done_d;
    logic                 init_q;

    logic accept;
    logic bit_end;
    logic timer_clear;
    logic last_data;
    logic last_stop;
    logic break_block;
    logic enter_tail;

`ifdef UART_TX_BREAK_EN
    localparam int unsigned BrkBits = DATA_SIZE + 2;
    localparam int unsigned BrkW    = $clog2(BrkBits + 1);
    localparam logic [BrkW-1:0] BrkSat  = BrkW'(BrkBits);
    localparam logic [BrkW-1:0] BrkLast = BrkW'(BrkBits - 1);

    logic [BrkW-1:0] brk_cnt_q, brk_cnt_d;
    logic            tail_q, tail_d;
    logic            min_met;

    // Break wins over a pending word, so the word must not be handshaken away.
    assign break_block = send_break;
    assign min_met     = (brk_cnt_q == BrkSat) || (bit_end && (brk_cnt_q == BrkLast));
    assign enter_tail  = (state_q == StBreak) && !tail_q && min_met && !send_break;
`else
    logic unused_send_break;

    assign unused_send_break = send_break;
    assign break_block       = 1'b0;
    assign enter_tail        = 1'b0;
`endif

    assign tx_busy         = (state_q != StIdle);
    assign tx_ready        = (state_q == StIdle) && init_q && !break_block;
    assign serial_data_out = line_q;
    assign tx_done         = done_q;

    assign accept      = tx_valid && tx_ready;
    assign last_data   = (bit_cnt_q == BitLast);
    assign last_stop   = !two_stop_q || (bit_cnt_q == BitW'(1));
    // Holding the timer at zero in IDLE makes the accept-cycle tick irrelevant.
    assign timer_clear = (state_q == StIdle) || enter_tail;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .baud_tick(baud_tick),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
`ifdef UART_TX_BREAK_EN
                if (init_q && send_break) begin
                    state_d = StBreak;
                end else if (accept) begin
                    state_d = StStart;
                end
`else
                if (accept) begin
                    state_d = StStart;
                end
`endif
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && last_data) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end && last_stop) begin
                    state_d = StIdle;
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                if (bit_end && tail_q) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        if (accept) begin
            shift_d    = data_in;
            bit_cnt_d  = '0;
            par_en_d   = cfg_parity_en;
            par_bit_d  = calc_parity(9'(data_in), cfg_parity_odd);
            two_stop_d = cfg_two_stop;
        end else if (bit_end) begin
            if (state_q == StData) begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = last_data ? '0 : bit_cnt_q + BitW'(1);
            end else if (state_q == StStop) begin
                bit_cnt_d = bit_cnt_q + BitW'(1);
            end
        end
    end

`ifdef UART_TX_BREAK_EN
    always_comb begin
        brk_cnt_d = brk_cnt_q;
        tail_d    = tail_q;
        if (state_q != StBreak) begin
            brk_cnt_d = '0;
            tail_d    = 1'b0;
        end else begin
            if (bit_end && (brk_cnt_q != BrkSat)) begin
                brk_cnt_d = brk_cnt_q + BrkW'(1);
            end
            if (enter_tail) begin
                tail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk_cnt_q <= '0;
            tail_q    <= 1'b0;
        end else begin
            brk_cnt_q <= brk_cnt_d;
            tail_q    <= tail_d;
        end
    end
`endif

    // Line and done are registered from the next state so the start bit follows the accept edge.
    always_comb begin
        line_d = 1'b1;
        unique case (state_d)
            StIdle:   line_d = 1'b1;
            StStart:  line_d = 1'b0;
            StData:   line_d = shift_d[0];
            StParity: line_d = par_bit_q;
            StStop:   line_d = 1'b1;
`ifdef UART_TX_BREAK_EN
            StBreak:  line_d = tail_d;
`endif
            default:  line_d = 1'b1;
        endcase
        done_d = (state_q == StStop) && (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            line_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            line_q     <= line_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer (DATA_SIZE=8, OVERSAMPLE=16, baud_tick tied high).
// Break scenario is exercised when UART_TX_BREAK_EN is defined.
module tb_uart_tx_framer;

    logic       clk            = 1'b0;
    logic       reset          = 1'b0;
    logic       baud_tick      = 1'b1;
    logic       tx_valid       = 1'b0;
    logic [7:0] data_in        = 8'h00;
    logic       cfg_parity_en  = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_two_stop   = 1'b0;
    logic       send_break     = 1'b0;
    logic       tx_ready;
    logic       serial_data_out;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fails  = 0;

    logic       line_hist [0:599];
    logic [7:0] words [3];
    int         acc_t [3];
    int         done_at [3];
    int         n_acc;
    int         rdy_cnt;
    int         done_cnt;
    int         low_cnt;
    int         high_cnt;
    int         first_high;
    int         first_ready;
    logic       acc;

    always #5 clk = ~clk;

    uart_tx_framer #(
        .DATA_SIZE (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .baud_tick      (baud_tick),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .data_in        (data_in),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .send_break     (send_break),
        .serial_data_out(serial_data_out),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one word from IDLE and checks every bit boundary plus the done/ready handover.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic po,
                             input logic ts, input logic scramble, input string tag);
        logic exp_bits [12];
        int   nb;
        int   ndone;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i + 1] = d[i];
        nb = 9;
        if (pe) begin
            exp_bits[nb] = (^d) ^ po;
            nb = nb + 1;
        end
        exp_bits[nb] = 1'b1;
        nb = nb + 1;
        if (ts) begin
            exp_bits[nb] = 1'b1;
            nb = nb + 1;
        end
        data_in        = d;
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_two_stop   = ts;
        tx_valid       = 1'b1;
        chk1({tag, "_ready_idle"}, tx_ready, 1'b1);
        tick_n(1);
        tx_valid = 1'b0;
        if (scramble) begin
            data_in        = ~d;
            cfg_parity_en  = ~pe;
            cfg_parity_odd = ~po;
            cfg_two_stop   = ~ts;
        end
        ndone = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < 16; c++) begin
                if (c == 0 || c == 15)
                    chk1($sformatf("%s_bit%0d_c%0d", tag, b, c), serial_data_out, exp_bits[b]);
                if (c == 8) begin
                    chk1($sformatf("%s_busy_b%0d", tag, b), tx_busy, 1'b1);
                    chk1($sformatf("%s_ready_b%0d", tag, b), tx_ready, 1'b0);
                end
                if (tx_done) ndone++;
                tick_n(1);
            end
        end
        chk1({tag, "_done"}, tx_done, 1'b1);
        chk1({tag, "_ready_end"}, tx_ready, 1'b1);
        chk1({tag, "_busy_end"}, tx_busy, 1'b0);
        chki({tag, "_early_done"}, ndone, 0);
        tick_n(1);
        chk1({tag, "_done_width"}, tx_done, 1'b0);
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        words = '{8'h01, 8'h02, 8'h03};

        // Reset values, then tx_ready one clock after release.
        #1 reset = 1'b1;
        #2;
        chk1("rst_line", serial_data_out, 1'b1);
        chk1("rst_busy", tx_busy, 1'b0);
        chk1("rst_done", tx_done, 1'b0);
        chk1("rst_ready", tx_ready, 1'b0);
        #19 reset = 1'b0;
        #1;
        chk1("ready_before_clk", tx_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("ready_after_clk", tx_ready, 1'b1);
        chk1("idle_line", serial_data_out, 1'b1);

        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "f8n1");
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "feven");
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "fodd");
        run_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "f2stop");

        // Back-to-back frames with tx_valid held high.
        n_acc    = 0;
        rdy_cnt  = 0;
        done_cnt = 0;
        data_in  = words[0];
        tx_valid = 1'b1;
        for (int s = 0; s < 600; s++) begin
            line_hist[s] = serial_data_out;
            if (tx_done) begin
                if (done_cnt < 3) done_at[done_cnt] = s;
                done_cnt++;
            end
            acc = tx_valid && tx_ready;
            if (tx_valid && tx_ready) rdy_cnt++;
            if (acc && n_acc < 3) acc_t[n_acc] = s;
            tick_n(1);
            if (acc) begin
                n_acc++;
                if (n_acc < 3) data_in = words[n_acc];
                else tx_valid = 1'b0;
            end
        end
        chki("b2b_accepts", n_acc, 3);
        chki("b2b_ready_cycles", rdy_cnt, 3);
        chki("b2b_done_pulses", done_cnt, 3);
        chki("b2b_acc0", acc_t[0], 0);
        chki("b2b_acc1", acc_t[1], 161);
        chki("b2b_acc2", acc_t[2], 322);
        chki("b2b_done0", done_at[0], 161);
        chki("b2b_done1", done_at[1], 322);
        chki("b2b_done2", done_at[2], 483);
        for (int k = 0; k < 3; k++) begin
            chk1($sformatf("b2b_f%0d_start", k), line_hist[k * 161 + 1], 1'b0);
            for (int b = 0; b < 8; b++)
                chk1($sformatf("b2b_f%0d_d%0d", k, b), line_hist[k * 161 + 1 + 16 * (b + 1) + 8],
                     words[k][b]);
            chk1($sformatf("b2b_f%0d_stop", k), line_hist[k * 161 + 1 + 16 * 9 + 8], 1'b1);
        end

        // Asynchronous reset during data bit 3 of 0xA5 (a zero bit).
        data_in  = 8'hA5;
        tx_valid = 1'b1;
        tick_n(1);
        tx_valid = 1'b0;
        tick_n(16 * 4 + 5);
        chk1("mid_line_before", serial_data_out, 1'b0);
        chk1("mid_busy_before", tx_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("mid_rst_line", serial_data_out, 1'b1);
        chk1("mid_rst_busy", tx_busy, 1'b0);
        chk1("mid_rst_ready", tx_ready, 1'b0);
        chk1("mid_rst_done", tx_done, 1'b0);
        #2 reset = 1'b0;
        done_cnt = 0;
        low_cnt  = 0;
        for (int s = 0; s < 200; s++) begin
            tick_n(1);
            if (tx_done) done_cnt++;
            if (!serial_data_out) low_cnt++;
        end
        chki("mid_no_done", done_cnt, 0);
        chki("mid_line_idle", low_cnt, 0);
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "fpost");

`ifdef UART_TX_BREAK_EN
        // Short break request: minimum frame-time low, one bit high, then IDLE.
        send_break = 1'b1;
        tx_valid   = 1'b1;
        data_in    = 8'h55;
        tick_n(1);
        tx_valid = 1'b0;
        chk1("brk_busy", tx_busy, 1'b1);
        chk1("brk_ready", tx_ready, 1'b0);
        low_cnt     = 0;
        high_cnt    = 0;
        first_high  = -1;
        first_ready = -1;
        done_cnt    = 0;
        for (int s = 1; s < 200; s++) begin
            if (s == 10) send_break = 1'b0;
            if (!serial_data_out) low_cnt++;
            else if (first_high < 0) first_high = s;
            if (s >= 161 && s <= 176 && serial_data_out) high_cnt++;
            if (tx_ready && first_ready < 0) first_ready = s;
            if (tx_done) done_cnt++;
            tick_n(1);
        end
        chki("brk_low_cycles", low_cnt, 160);
        chki("brk_first_high", first_high, 161);
        chki("brk_tail_high", high_cnt, 16);
        chki("brk_first_ready", first_ready, 177);
        chki("brk_no_done", done_cnt, 0);
`else
        // Without the break feature send_break must have no effect.
        send_break = 1'b1;
        tick_n(5);
        chk1("nobrk_busy", tx_busy, 1'b0);
        chk1("nobrk_ready", tx_ready, 1'b1);
        chk1("nobrk_line", serial_data_out, 1'b1);
        send_break = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
